// File: rtl/m2p_serializer.sv
// Method-to-pipe marshaller: per-channel one-entry holding buffers, round-robin
// arbitration, and serialisation as a header beat plus payload beats onto the enq pipe.
module m2p_serializer #(
    parameter int unsigned NUM_METHODS = 4,
    parameter int unsigned PAYLOAD_WIDTH = 128,
    parameter int unsigned BEAT_WIDTH = 32,
    parameter logic [16*NUM_METHODS-1:0] METHOD_BEATS = {16'd4, 16'd4, 16'd2, 16'd1}
) (
    input  logic                                 CLK,
    input  logic                                 nRST,
    input  logic [NUM_METHODS-1:0]               method_ENA,
    input  logic [NUM_METHODS*PAYLOAD_WIDTH-1:0] method_v,
    output logic [NUM_METHODS-1:0]               method_RDY,
    output logic                                 pipe_enq__ENA,
    output logic [BEAT_WIDTH-1:0]                pipe_enq_v,
    input  logic                                 pipe_enq__RDY
);

    localparam int unsigned SEL_W = (NUM_METHODS > 1) ? $clog2(NUM_METHODS) : 1;
    localparam int unsigned MAX_BEATS = PAYLOAD_WIDTH / BEAT_WIDTH;
    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_SEND
    } state_e;

    state_e                   state_q, state_d;
    logic [NUM_METHODS-1:0]   held_q, held_d;
    logic [PAYLOAD_WIDTH-1:0] payload_q [NUM_METHODS];
    logic [PAYLOAD_WIDTH-1:0] payload_d [NUM_METHODS];
    logic [SEL_W-1:0]         rr_q, rr_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [NUM_METHODS-1:0]   cap_c;
    logic [SEL_W-1:0]         grant_c;
    logic                     found_c;
    logic [15:0]              nb_c;
    logic                     last_c;
    logic [BEAT_WIDTH-1:0]    beat_c;
    logic                     enq_ena_c;
    logic [SEL_W-1:0]         next_rr_c;

    // Round-robin grant: first held channel at or after rr_q, wrapping.
    always_comb begin
        logic [SEL_W-1:0] idx;
        grant_c = '0;
        found_c = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NUM_METHODS; i++) begin
            idx = SEL_W'((32'(rr_q) + i) % NUM_METHODS);
            if (!found_c && held_q[idx]) begin
                found_c = 1'b1;
                grant_c = idx;
            end
        end
    end

    // Beat content for the selected channel; beat 0 is the header.
    always_comb begin
        nb_c   = '0;
        beat_c = '0;
        for (int unsigned i = 0; i < NUM_METHODS; i++) begin
            if (sel_q == SEL_W'(i)) begin
                nb_c = METHOD_BEATS[i*16 +: 16];
            end
        end
        if (cnt_q == '0) begin
            beat_c = BEAT_WIDTH'({16'(sel_q), nb_c + 16'd1});
        end else begin
            for (int unsigned k = 0; k < MAX_BEATS; k++) begin
                if (cnt_q == CNT_W'(k + 1)) begin
                    beat_c = payload_q[sel_q][k*BEAT_WIDTH +: BEAT_WIDTH];
                end
            end
        end
    end

    always_comb begin
        enq_ena_c = (state_q == ST_SEND) && pipe_enq__RDY;
        last_c    = (16'(cnt_q) == nb_c);
        next_rr_c = (32'(sel_q) == NUM_METHODS - 1) ? '0 : sel_q + SEL_W'(1);
    end

    // Next-state: captures, arbitration and beat sequencing.
    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        payload_d = payload_q;
        rr_d      = rr_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;

        cap_c = method_ENA & ~held_q;
        for (int unsigned i = 0; i < NUM_METHODS; i++) begin
            if (cap_c[i]) begin
                payload_d[i] = method_v[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
            end
        end
        held_d = held_q | cap_c;

        case (state_q)
            ST_IDLE: begin
                if (found_c) begin
                    sel_d   = grant_c;
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (enq_ena_c) begin
                    if (last_c) begin
                        held_d[sel_q] = 1'b0;
                        rr_d          = next_rr_c;
                        cnt_d         = '0;
                        state_d       = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state_q   <= ST_IDLE;
            held_q    <= '0;
            payload_q <= '{default: '0};
            rr_q      <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            held_q    <= held_d;
            payload_q <= payload_d;
            rr_q      <= rr_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
        end
    end

    // Beat handshake follows pipe readiness directly; data is zero when idle.
    assign method_RDY    = ~held_q;
    assign pipe_enq__ENA = enq_ena_c;
    assign pipe_enq_v    = enq_ena_c ? beat_c : '0;

endmodule

// File: tb/tb_m2p_serializer.sv
// Bench for m2p_serializer: directed scenarios plus random traffic, checked against
// a transaction-level model built from per-channel flags and an expected-beat queue.
module tb_m2p_serializer;

    localparam int unsigned NM = 4;
    localparam int unsigned PW = 128;
    localparam int unsigned BW = 32;
    localparam logic [16*NM-1:0] NB = {16'd4, 16'd4, 16'd2, 16'd1};

    logic             CLK = 1'b0;
    logic             nRST;
    logic [NM-1:0]    tb_ena;
    logic [NM*PW-1:0] tb_v;
    logic [NM-1:0]    dut_rdy;
    logic             p_ena;
    logic [BW-1:0]    p_v;
    logic             p_rdy;

    always #5 CLK = ~CLK;

    m2p_serializer dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .method_ENA   (tb_ena),
        .method_v     (tb_v),
        .method_RDY   (dut_rdy),
        .pipe_enq__ENA(p_ena),
        .pipe_enq_v   (p_v),
        .pipe_enq__RDY(p_rdy)
    );

    int n_vec = 0;
    int n_err = 0;

    bit            m_held [NM];
    logic [PW-1:0] m_pay  [NM];
    int            m_rr;
    int            m_sel;
    bit            m_busy;
    int            m_pos;
    logic [BW-1:0] m_q[$];
    logic [BW-1:0] log_q[$];
    logic [BW-1:0] hdr_log[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nbeats(input int ch);
        logic [16*NM-1:0] t;
        t = NB;
        return int'(t[ch*16 +: 16]);
    endfunction

    function automatic logic [PW-1:0] rnd_pay();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [NM*PW-1:0] mkv(input int ch, input logic [PW-1:0] val);
        logic [NM*PW-1:0] r;
        r = '0;
        r[ch*PW +: PW] = val;
        return r;
    endfunction

    function automatic logic [BW-1:0] hdr(input int ch);
        return BW'({16'(ch), 16'(nbeats(ch) + 1)});
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NM; i++) begin
            m_held[i] = 0;
            m_pay[i]  = '0;
        end
        m_rr = 0; m_sel = 0; m_busy = 0; m_pos = 0;
        m_q.delete();
        log_q.delete();
        hdr_log.delete();
    endtask

    // One clock: drive, check mid-cycle, advance model across the edge.
    task automatic step(input logic [NM-1:0] ena, input logic [NM*PW-1:0] v, input logic rdy);
        logic [NM-1:0] exp_rdy;
        logic [NM-1:0] cap;
        logic          exp_ena;
        logic [BW-1:0] exp_v;
        tb_ena = ena;
        tb_v   = v;
        p_rdy  = rdy;
        @(negedge CLK);
        for (int i = 0; i < NM; i++) exp_rdy[i] = !m_held[i];
        exp_ena = m_busy && rdy;
        exp_v   = exp_ena ? m_q[0] : '0;
        check("rdy", 64'(dut_rdy), 64'(exp_rdy));
        check("ena", 64'(p_ena), 64'(exp_ena));
        check("data", 64'(p_v), 64'(exp_v));
        if (p_ena) begin
            log_q.push_back(p_v);
            if (m_pos == 0) hdr_log.push_back(p_v);
        end
        for (int i = 0; i < NM; i++) cap[i] = ena[i] && !m_held[i];
        if (exp_ena) begin
            void'(m_q.pop_front());
            m_pos++;
            if (m_q.size() == 0) begin
                m_held[m_sel] = 0;
                m_rr   = (m_sel + 1) % NM;
                m_busy = 0;
            end
        end else if (!m_busy) begin
            for (int k = 0; k < NM; k++) begin
                int c;
                c = (m_rr + k) % NM;
                if (!m_busy && m_held[c]) begin
                    m_sel  = c;
                    m_busy = 1;
                    m_pos  = 0;
                    m_q.push_back(hdr(c));
                    for (int b = 0; b < nbeats(c); b++) m_q.push_back(m_pay[c][b*BW +: BW]);
                end
            end
        end
        for (int i = 0; i < NM; i++) begin
            if (cap[i]) begin
                m_held[i] = 1;
                m_pay[i]  = v[i*PW +: PW];
            end
        end
        @(posedge CLK);
        #1;
        tb_ena = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b1);
    endtask

    task automatic do_reset(input int cycles);
        nRST   = 1'b1;
        tb_ena = '0;
        p_rdy  = 1'b1;
        #1;
        model_reset();
        check("rst_rdy", 64'(dut_rdy), 64'(4'hF));
        check("rst_ena", 64'(p_ena), 64'(0));
        check("rst_data", 64'(p_v), 64'(0));
        repeat (cycles) @(posedge CLK);
        #1;
        nRST = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] pay;
        logic [PW-1:0] p3;
        int ord[5];
        tb_ena = '0;
        tb_v   = '0;
        p_rdy  = 1'b1;

        do_reset(3);

        // Single ch0 message with a one-beat payload.
        step(4'b0001, mkv(0, 128'hAB), 1'b1);
        idle(6);
        check("ch0_len", 64'(log_q.size()), 64'(2));
        if (log_q.size() == 2) begin
            check("ch0_hdr", 64'(log_q[0]), 64'h0000_0002);
            check("ch0_pay", 64'(log_q[1]), 64'h0000_00AB);
        end

        // ch2: four payload beats, LSB slice first.
        log_q.delete();
        step(4'b0100, mkv(2, 128'h4444_4444_3333_3333_2222_2222_1111_1111), 1'b1);
        idle(8);
        check("ch2_len", 64'(log_q.size()), 64'(5));
        if (log_q.size() == 5) begin
            check("ch2_b0", 64'(log_q[0]), 64'h0002_0005);
            check("ch2_b1", 64'(log_q[1]), 64'h1111_1111);
            check("ch2_b2", 64'(log_q[2]), 64'h2222_2222);
            check("ch2_b3", 64'(log_q[3]), 64'h3333_3333);
            check("ch2_b4", 64'(log_q[4]), 64'h4444_4444);
        end

        // All channels at once, then ch0 refired during ch1's message.
        do_reset(2);
        step(4'b1111, {rnd_pay(), rnd_pay(), rnd_pay(), rnd_pay()}, 1'b1);
        for (int n = 0; n < 30 && !(m_busy && m_sel == 1); n++) step('0, '0, 1'b1);
        check("wait_ch1", 64'(m_busy && m_sel == 1), 64'(1));
        step(4'b0001, mkv(0, rnd_pay()), 1'b1);
        idle(40);
        ord = '{0, 1, 2, 3, 0};
        check("rr_cnt", 64'(hdr_log.size()), 64'(5));
        for (int i = 0; i < 5 && i < hdr_log.size(); i++) check("rr_hdr", 64'(hdr_log[i]), 64'(hdr(ord[i])));
        hdr_log.delete();
        step(4'b1111, {rnd_pay(), rnd_pay(), rnd_pay(), rnd_pay()}, 1'b1);
        idle(40);
        ord = '{1, 2, 3, 0, 0};
        check("wrap_cnt", 64'(hdr_log.size()), 64'(4));
        for (int i = 0; i < 4 && i < hdr_log.size(); i++) check("wrap_hdr", 64'(hdr_log[i]), 64'(hdr(ord[i])));

        // Back-pressure for three cycles after beat 2 of a ch3 message.
        log_q.delete();
        step(4'b1000, mkv(3, 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA), 1'b1);
        for (int n = 0; n < 30 && !(m_busy && m_sel == 3 && m_pos == 3); n++) step('0, '0, 1'b1);
        check("wait_ch3", 64'(m_busy && m_sel == 3 && m_pos == 3), 64'(1));
        repeat (3) step('0, '0, 1'b0);
        idle(6);
        check("stall_len", 64'(log_q.size()), 64'(5));
        if (log_q.size() == 5) begin
            check("stall_b0", 64'(log_q[0]), 64'h0003_0005);
            check("stall_b1", 64'(log_q[1]), 64'hAAAA_AAAA);
            check("stall_b2", 64'(log_q[2]), 64'hBBBB_BBBB);
            check("stall_b3", 64'(log_q[3]), 64'hCCCC_CCCC);
            check("stall_b4", 64'(log_q[4]), 64'hDDDD_DDDD);
        end

        // Reset during beat 1 of ch1 with ch2 held abandons everything.
        step(4'b0010, mkv(1, rnd_pay()), 1'b1);
        step(4'b0100, mkv(2, rnd_pay()), 1'b1);
        for (int n = 0; n < 30 && !(m_busy && m_sel == 1 && m_pos == 1); n++) step('0, '0, 1'b1);
        check("wait_ch1b", 64'(m_busy && m_sel == 1 && m_pos == 1), 64'(1));
        do_reset(2);
        idle(6);
        check("post_rst_beats", 64'(log_q.size()), 64'(0));
        step(4'b0100, mkv(2, 128'h4444_4444_3333_3333_2222_2222_1111_1111), 1'b1);
        idle(8);
        check("post_rst_len", 64'(log_q.size()), 64'(5));
        if (log_q.size() > 0) check("post_rst_hdr", 64'(log_q[0]), 64'h0002_0005);

        // Refire of ch1 on its final-beat edge is dropped; next cycle accepted.
        step(4'b0010, mkv(1, rnd_pay()), 1'b1);
        for (int n = 0; n < 30 && !(m_busy && m_sel == 1 && m_q.size() == 1); n++) step('0, '0, 1'b1);
        check("wait_last", 64'(m_busy && m_sel == 1 && m_q.size() == 1), 64'(1));
        step(4'b0010, mkv(1, rnd_pay()), 1'b1);
        log_q.delete();
        p3 = rnd_pay();
        step(4'b0010, mkv(1, p3), 1'b1);
        idle(8);
        check("refire_len", 64'(log_q.size()), 64'(3));
        if (log_q.size() == 3) begin
            check("refire_hdr", 64'(log_q[0]), 64'h0001_0003);
            check("refire_b1", 64'(log_q[1]), 64'(p3[31:0]));
            check("refire_b2", 64'(log_q[2]), 64'(p3[63:32]));
        end

        // Random traffic with random back-pressure.
        for (int n = 0; n < 1500; n++) begin
            logic [NM-1:0] e;
            for (int i = 0; i < NM; i++) e[i] = ($urandom_range(0, 3) == 0);
            pay = rnd_pay();
            step(e, {rnd_pay(), rnd_pay(), rnd_pay(), pay}, $urandom_range(0, 3) != 0);
        end
        idle(60);
        check("drain", 64'(m_busy), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
